// File: rtl/hex_step_pkg.sv
// hex_step_pkg: shared constants for the HEX0 ring scheduler.
package hex_step_pkg;
  localparam int IDX_W = 3;
  localparam int RING = 5;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RING - 1);
  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_AUTO = 2'b01;
  localparam logic [1:0] MODE_PAUSED = 2'b10;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  function automatic logic [6:0] seg_of(input logic [IDX_W-1:0] i);
    return i == 3'd0 ? SEG_3 : i == 3'd1 ? SEG_7 : i == 3'd2 ? SEG_2 :
           i == 3'd3 ? SEG_4 : i == 3'd4 ? SEG_6 : SEG_3;
  endfunction
endpackage

// File: rtl/hex_step_scheduler_if.sv
// hex_step_scheduler_if: control inputs and display outputs of the ring scheduler.
interface hex_step_scheduler_if;
  import hex_step_pkg::*;
  logic btn_step;
  logic dir_in;
  logic auto_en;
  logic pause;
  logic step_pulse;
  logic step_dir;
  logic [IDX_W-1:0] index;
  logic [6:0] hex_out;
  logic [1:0] mode;
  modport master (output btn_step, dir_in, auto_en, pause,
                  input step_pulse, step_dir, index, hex_out, mode);
  modport slave (input btn_step, dir_in, auto_en, pause,
                 output step_pulse, step_dir, index, hex_out, mode);
endinterface

// File: rtl/hex_step_scheduler_btn_sync_edge.sv
// btn_sync_edge: multi-flop synchronizer plus rising-edge detector.
module btn_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);
  logic [STAGES-1:0] sync;
  logic prev;
  // History resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], raw};
      prev <= sync[STAGES-1];
    end
  end
  assign rise = sync[STAGES-1] & ~prev;
endmodule

// File: rtl/hex_step_scheduler.sv
// hex_step_scheduler: manual/auto stepping of the five-digit HEX0 ring.
module hex_step_scheduler
  import hex_step_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  hex_step_scheduler_if.slave bus
);
  localparam int TW = $clog2(TICK_DIV);
  logic [TW-1:0] timer;
  logic man_edge, auto_tick, step;
  logic [1:0] mode_nxt;
  logic [IDX_W-1:0] idx_nxt;
  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_btn (
    .clk(clk),
    .reset(reset),
    .raw(bus.btn_step),
    .rise(man_edge)
  );
  assign mode_nxt = !bus.auto_en ? MODE_MANUAL : bus.pause ? MODE_PAUSED : MODE_AUTO;
  assign auto_tick = bus.mode == MODE_AUTO && timer == TW'(TICK_DIV - 1);
  assign step = man_edge | auto_tick;
  // Out-of-ring indices recover to position 0 on the next step.
  assign idx_nxt = bus.index > IDX_LAST ? '0 :
                   bus.dir_in ? (bus.index == IDX_LAST ? '0 : bus.index + 1'b1) :
                   (bus.index == '0 ? IDX_LAST : bus.index - 1'b1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
      bus.mode <= MODE_MANUAL;
      bus.index <= '0;
      bus.hex_out <= SEG_3;
      bus.step_pulse <= 1'b0;
      bus.step_dir <= 1'b1;
    end else begin
      bus.mode <= mode_nxt;
      timer <= (bus.mode == MODE_MANUAL || auto_tick) ? '0 :
               bus.mode == MODE_AUTO ? timer + 1'b1 : timer;
      bus.step_pulse <= step;
      if (step) begin
        bus.index <= idx_nxt;
        bus.hex_out <= seg_of(idx_nxt);
        bus.step_dir <= bus.dir_in;
      end
    end
  end
endmodule
